// File: rtl/status_flag_controller_if.sv
// Purpose: bus bundle between the execute stage / branch unit and the status
//          flag controller.
// Signals:
//   alu_valid/alu_ready/alu_result/alu_carry/alu_overflow/alu_mask
//                                   ALU flag update request
//   sw_wr_valid/sw_wr_ready/sw_wr_data
//                                   software status write request
//   save_req/restore_req/sr_ack/sr_err/stack_full/stack_empty
//                                   interrupt save/restore of the flags
//   cond_code/cond_true             branch condition evaluation
//   status_value/busy               committed flags {Z,N,C,V}, controller busy
// Modports: master = requester side, slave = controller side.
interface status_flag_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic [3:0]            alu_mask;
  logic                  sw_wr_valid;
  logic                  sw_wr_ready;
  logic [3:0]            sw_wr_data;
  logic                  save_req;
  logic                  restore_req;
  logic                  sr_ack;
  logic                  sr_err;
  logic                  stack_full;
  logic                  stack_empty;
  logic [3:0]            cond_code;
  logic                  cond_true;
  logic [3:0]            status_value;
  logic                  busy;

  modport master (
    output alu_valid, alu_result, alu_carry, alu_overflow, alu_mask,
    output sw_wr_valid, sw_wr_data, save_req, restore_req, cond_code,
    input  alu_ready, sw_wr_ready, sr_ack, sr_err, stack_full, stack_empty,
    input  cond_true, status_value, busy
  );

  modport slave (
    input  alu_valid, alu_result, alu_carry, alu_overflow, alu_mask,
    input  sw_wr_valid, sw_wr_data, save_req, restore_req, cond_code,
    output alu_ready, sw_wr_ready, sr_ack, sr_err, stack_full, stack_empty,
    output cond_true, status_value, busy
  );
endinterface

// File: rtl/status_flag_controller.sv
// Purpose: sole writer of the 4-bit status flags {Z,N,C,V}. Arbitrates
//          restore > save > software write > ALU update, one grant per idle
//          cycle, commits the selected update one edge after acceptance and
//          evaluates branch condition codes against the committed flags.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-low reset
//   io_bus   status_flag_controller_if.slave (requests, handshakes, flags,
//            save/restore status, condition evaluation, busy)
// Configuration:
//   FLAG_STACK_EN  defined   : save/restore flag stack of STACK_DEPTH entries
//                  undefined : no stack; save/restore requests are ignored
module status_flag_controller #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  status_flag_controller_if.slave        io_bus
);

  localparam int unsigned FW    = 4;
  localparam int unsigned V_BIT = 0;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned N_BIT = 2;
  localparam int unsigned Z_BIT = 3;

`ifdef FLAG_STACK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_STACK  = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;
`endif

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_alu_grant;
  logic            w_sw_grant;
  logic [FW-1:0]   r_flags;
  logic [FW-1:0]   r_pend_new;
  logic [FW-1:0]   r_pend_mask;
  logic [FW-1:0]   w_alu_flags;
  logic            w_cond;

`ifdef FLAG_STACK_EN
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  logic            w_save_grant;
  logic            w_restore_grant;
  logic [SPW-1:0]  r_sp;
  logic [FW-1:0]   r_stack [STACK_DEPTH];
  logic            r_op_restore;
  logic            r_sr_err;
  logic            w_stack_full;
  logic            w_stack_empty;
  logic            w_stack_apply;
  logic [FW-1:0]   w_pop_flags;
`else
  logic            w_unused_cfg;
  assign w_unused_cfg = ^{io_bus.save_req, io_bus.restore_req, 32'(STACK_DEPTH)};
`endif

  // Candidate flags from the ALU result, ordered {Z,N,C,V}
  assign w_alu_flags = {(io_bus.alu_result == '0),
                        io_bus.alu_result[DATA_WIDTH-1],
                        io_bus.alu_carry,
                        io_bus.alu_overflow};

  // Next-state and grant arbitration
  always_comb begin
    w_state_nxt = r_state;
    w_alu_grant = 1'b0;
    w_sw_grant  = 1'b0;
`ifdef FLAG_STACK_EN
    w_save_grant    = 1'b0;
    w_restore_grant = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef FLAG_STACK_EN
        if (io_bus.restore_req) begin
          w_restore_grant = 1'b1;
          w_state_nxt     = ST_STACK;
        end else if (io_bus.save_req) begin
          w_save_grant = 1'b1;
          w_state_nxt  = ST_STACK;
        end else
`endif
        if (io_bus.sw_wr_valid) begin
          w_sw_grant  = 1'b1;
          w_state_nxt = ST_COMMIT;
        end else if (io_bus.alu_valid) begin
          w_alu_grant = 1'b1;
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
`ifdef FLAG_STACK_EN
      ST_STACK:  w_state_nxt = ST_IDLE;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pending update capture and flag commit
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_pend_new  <= '0;
      r_pend_mask <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sw_grant) begin
        r_pend_new  <= io_bus.sw_wr_data;
        r_pend_mask <= '1;
      end else if (w_alu_grant) begin
        r_pend_new  <= w_alu_flags;
        r_pend_mask <= io_bus.alu_mask;
      end
      if (r_state == ST_COMMIT) begin
        r_flags <= (r_pend_mask & r_pend_new) | (~r_pend_mask & r_flags);
      end
`ifdef FLAG_STACK_EN
      else if (w_stack_apply && r_op_restore) begin
        r_flags <= w_pop_flags;
      end
`endif
    end
  end

`ifdef FLAG_STACK_EN
  assign w_stack_full  = (r_sp == SPW'(STACK_DEPTH));
  assign w_stack_empty = (r_sp == '0);
  // An erroring push/pop leaves both stack and flags untouched
  assign w_stack_apply = (r_state == ST_STACK) && !r_sr_err;

  // Top-of-stack read (entry below the pointer)
  always_comb begin
    w_pop_flags = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (SPW'(i) == (r_sp - SPW'(1))) w_pop_flags = r_stack[i];
    end
  end

  // Operation type and error are fixed at grant; the stack cannot change before STACK
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sp         <= '0;
      r_op_restore <= 1'b0;
      r_sr_err     <= 1'b0;
    end else begin
      if (w_restore_grant) begin
        r_op_restore <= 1'b1;
        r_sr_err     <= w_stack_empty;
      end else if (w_save_grant) begin
        r_op_restore <= 1'b0;
        r_sr_err     <= w_stack_full;
      end
      if (w_stack_apply) begin
        r_sp <= r_op_restore ? (r_sp - SPW'(1)) : (r_sp + SPW'(1));
      end
    end
  end

  // Stack storage needs no reset: only entries below the pointer are ever read
  always_ff @(posedge i_clock) begin
    if (i_reset && w_stack_apply && !r_op_restore) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (SPW'(i) == r_sp) r_stack[i] <= r_flags;
      end
    end
  end

  assign io_bus.sr_ack      = (r_state == ST_STACK);
  assign io_bus.sr_err      = (r_state == ST_STACK) && r_sr_err;
  assign io_bus.stack_full  = w_stack_full;
  assign io_bus.stack_empty = w_stack_empty;
`else
  assign io_bus.sr_ack      = 1'b0;
  assign io_bus.sr_err      = 1'b0;
  assign io_bus.stack_full  = 1'b0;
  assign io_bus.stack_empty = 1'b1;
`endif

  // Branch condition from committed flags only
  always_comb begin
    w_cond = 1'b0;
    case (io_bus.cond_code)
      4'd0:    w_cond =  r_flags[Z_BIT];
      4'd1:    w_cond = ~r_flags[Z_BIT];
      4'd2:    w_cond =  r_flags[C_BIT];
      4'd3:    w_cond = ~r_flags[C_BIT];
      4'd4:    w_cond =  r_flags[N_BIT];
      4'd5:    w_cond = ~r_flags[N_BIT];
      4'd6:    w_cond =  r_flags[V_BIT];
      4'd7:    w_cond = ~r_flags[V_BIT];
      4'd8:    w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign io_bus.alu_ready    = w_alu_grant;
  assign io_bus.sw_wr_ready  = w_sw_grant;
  assign io_bus.cond_true    = w_cond;
  assign io_bus.status_value = r_flags;
  assign io_bus.busy         = (r_state != ST_IDLE);

endmodule
